// File: rtl/qmath_pkg.sv
// Shared Q-format math definitions: default word geometry, arbiter FSM encoding
// and the requester-ID width helper.
package qmath_pkg;
  localparam int QM_N = 32;
  localparam int QM_Q = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int idw_f(input int nreq);
    return (nreq <= 1) ? 1 : $clog2(nreq);
  endfunction
endpackage

// File: rtl/qmult.sv
// Combinational sign-magnitude (N,Q) multiplier with truncation and an
// overflow flag for magnitude bits lost above the result window.
module qmult #(
  parameter int N = 32,
  parameter int Q = 16
) (
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  output logic [N-1:0] o_result,
  output logic         ovr
);
  logic [2*N-2:0] prod;
  logic [2*N-2:0] prod_sh;

  assign prod    = {{N{1'b0}}, i_multiplicand[N-2:0]} * {{N{1'b0}}, i_multiplier[N-2:0]};
  assign prod_sh = prod >> Q;

  // Negative zero is deliberately left as-is.
  assign o_result = {i_multiplicand[N-1] ^ i_multiplier[N-1], prod_sh[N-2:0]};
  assign ovr      = |prod_sh[2*N-2:N-1];
endmodule

// File: rtl/qmult_arbiter.sv
// Round-robin front end sharing one qmult among NREQ requesters; registered
// operands and responses, plus a saturating overflow counter for debug.
module qmult_arbiter
  import qmath_pkg::*;
#(
  parameter int N    = QM_N,
  parameter int Q    = QM_Q,
  parameter int NREQ = 4,
  parameter int IDW  = idw_f(NREQ),
  parameter int CNTW = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [NREQ*N-1:0] i_req_a,
  input  logic [NREQ*N-1:0] i_req_b,
  output logic [NREQ-1:0]   o_req_ready,
  output logic              o_rsp_valid,
  output logic [IDW-1:0]    o_rsp_id,
  output logic [N-1:0]      o_rsp_data,
  output logic              o_rsp_ovr,
  input  logic              i_rsp_ready,
  input  logic              i_clr_ovr_count,
  output logic [CNTW-1:0]   o_ovr_count,
  output logic              o_busy
);
  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  op_id_q, op_id_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [N-1:0]    rsp_data_q, rsp_data_d;
  logic            rsp_ovr_q, rsp_ovr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [N-1:0]    mul_res;
  logic            mul_ovr;
  logic            grant_vld;
  logic [IDW-1:0]  grant_idx;
  logic            rsp_hs;

  // First valid requester after ptr, wrapping; {found, index}.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] vld,
                                           input logic [IDW-1:0]  ptr);
    logic           found;
    logic [IDW-1:0] idx;
    int             k;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!found && vld[k]) begin
        found = 1'b1;
        idx   = IDW'(k);
      end
    end
    return {found, idx};
  endfunction

  assign {grant_vld, grant_idx} = rr_pick(i_req_valid, rr_ptr_q);
  assign rsp_hs = (state_q == RESP) && i_rsp_ready;

  qmult #(.N(N), .Q(Q)) u_qmult (
    .i_multiplicand (a_q),
    .i_multiplier   (b_q),
    .o_result       (mul_res),
    .ovr            (mul_ovr)
  );

  always_comb begin
    o_req_ready = '0;
    if (i_rst_n && state_q == IDLE && grant_vld) o_req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_id_d    = op_id_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_ovr_d  = rsp_ovr_q;
    unique case (state_q)
      IDLE: if (grant_vld) begin
        a_d     = i_req_a[grant_idx*N +: N];
        b_d     = i_req_b[grant_idx*N +: N];
        op_id_d = grant_idx;
        state_d = MUL;
      end
      MUL: begin
        rsp_data_d = mul_res;
        rsp_ovr_d  = mul_ovr;
        rsp_id_d   = op_id_q;
        state_d    = RESP;
      end
      RESP: if (i_rsp_ready) begin
        rr_ptr_d = rsp_id_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear wins over a same-cycle increment; saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr_ovr_count)                      cnt_d = '0;
    else if (rsp_hs && rsp_ovr_q && ~&cnt_q)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= IDW'(NREQ - 1);
      op_id_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_ovr_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_id_q    <= op_id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_ovr_q  <= rsp_ovr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_ovr   = rsp_ovr_q;
  assign o_ovr_count = cnt_q;
  assign o_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_qmult_arbiter.sv
// Scenario bench for qmult_arbiter: accepted requests push expected responses
// to a queue that a monitor pops on each response handshake.
module tb_qmult_arbiter;
  localparam int N = 32, Q = 16, NREQ = 4, IDW = 2, CNTW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*N-1:0] req_a = '0, req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_data;
  logic              rsp_ovr;
  logic              rsp_ready = 1'b1;
  logic              clr = 1'b0;
  logic [CNTW-1:0]   ovr_count;
  logic              busy;

  always #5 clk = ~clk;

  qmult_arbiter #(.N(N), .Q(Q), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_a(req_a),
    .i_req_b(req_b), .o_req_ready(req_ready), .o_rsp_valid(rsp_valid),
    .o_rsp_id(rsp_id), .o_rsp_data(rsp_data), .o_rsp_ovr(rsp_ovr),
    .i_rsp_ready(rsp_ready), .i_clr_ovr_count(clr), .o_ovr_count(ovr_count),
    .o_busy(busy)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [N-1:0]   data;
    logic           ovr;
  } exp_t;

  int   checks = 0, failures = 0, cyc = 0;
  exp_t sb[$];
  int   glog[$];
  int   gcyc[$];
  exp_t mon_e;
  int   mon_g;

  function automatic exp_t model(input logic [IDW-1:0] id, input logic [N-1:0] a,
                                 input logic [N-1:0] b);
    exp_t        e;
    logic [63:0] p;
    p      = {33'b0, a[30:0]} * {33'b0, b[30:0]};
    e.id   = id;
    e.data = {a[31] ^ b[31], p[46:16]};
    e.ovr  = |p[62:47];
    return e;
  endfunction

  // Monitor: one-hot ready, grant log, scoreboard push on accept / pop on response.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (rst_n) begin
      checks++;
      if ($countones(req_ready) > 1) begin
        failures++;
        $display("FAIL ready_onehot got=%b want at most one bit", req_ready);
      end
      if (|req_ready) begin
        mon_g = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) mon_g = i;
        sb.push_back(model(IDW'(mon_g), req_a[mon_g*N +: N], req_b[mon_g*N +: N]));
        glog.push_back(mon_g);
        gcyc.push_back(cyc);
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected got id=%0d data=%h want no response", rsp_id, rsp_data);
        end else begin
          mon_e = sb.pop_front();
          if (rsp_id !== mon_e.id || rsp_data !== mon_e.data || rsp_ovr !== mon_e.ovr) begin
            failures++;
            $display("FAIL sb_rsp got id=%0d data=%h ovr=%b want id=%0d data=%h ovr=%b",
                     rsp_id, rsp_data, rsp_ovr, mon_e.id, mon_e.data, mon_e.ovr);
          end
        end
      end
    end
  end

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && !busy) break;
    end
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain got pending=%0d busy=%b want 0 0", nm, sb.size(), busy);
    end
  endtask

  task automatic do_single(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] ed, input logic eo, input string nm);
    logic [NREQ-1:0] er;
    er = '0;
    er[k] = 1'b1;
    @(negedge clk);
    req_valid = er;
    req_a[k*N +: N] = a;
    req_b[k*N +: N] = b;
    #1;
    checks++;
    if (req_ready !== er) begin
      failures++;
      $display("FAIL %s_accept got ready=%b want %b", nm, req_ready, er);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_mul got valid=%b busy=%b want 0 1", nm, rsp_valid, busy);
    end
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_id !== IDW'(k) || rsp_ovr !== eo) begin
      failures++;
      $display("FAIL %s_rsp got v=%b data=%h id=%0d ovr=%b want v=1 data=%h id=%0d ovr=%b",
               nm, rsp_valid, rsp_data, rsp_id, rsp_ovr, ed, k, eo);
    end
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    #12;
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_data !== '0 ||
        rsp_ovr !== 1'b0 || ovr_count !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b v=%b id=%0d d=%h o=%b cnt=%0d busy=%b want zeros",
               req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovr, ovr_count, busy);
    end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    glog.delete();
    gcyc.delete();
    @(negedge clk);
    for (int k = 0; k < NREQ; k++) begin
      req_a[k*N +: N] = 32'((k + 1) << 16);
      req_b[k*N +: N] = 32'h0001_0000;
    end
    req_valid = 4'b1111;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (glog.size() >= 6) break;
    end
    req_valid = '0;
    checks++;
    if (glog.size() != 6) begin
      failures++;
      $display("FAIL rr_count got=%0d want 6", glog.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (glog[i] != i % NREQ) begin
          failures++;
          $display("FAIL rr_order[%0d] got=%0d want %0d", i, glog[i], i % NREQ);
        end
        if (i > 0) begin
          checks++;
          if (gcyc[i] - gcyc[i-1] != 3) begin
            failures++;
            $display("FAIL rr_spacing[%0d] got=%0d want 3", i, gcyc[i] - gcyc[i-1]);
          end
        end
      end
    end
    wait_drain("rr");
  endtask

  task automatic test_basic();
    do_single(0, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 1'b0, "pos");
    do_single(2, 32'h8001_8000, 32'h0002_0000, 32'h8003_0000, 1'b0, "neg");
    wait_drain("basic");
  endtask

  task automatic test_ovr_clear();
    do_single(1, 32'h7FFF_0000, 32'h0002_0000, 32'h7FFE_0000, 1'b1, "ovr");
    @(negedge clk); #1;
    checks++;
    if (ovr_count !== 16'd1) begin
      failures++;
      $display("FAIL ovr_count got=%0d want 1", ovr_count);
    end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    checks++;
    if (ovr_count !== 16'd0) begin
      failures++;
      $display("FAIL ovr_clear got=%0d want 0", ovr_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0]   hd;
    logic [IDW-1:0] hid;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 4'b0100;
    req_a[2*N +: N] = 32'h0002_8000;
    req_b[2*N +: N] = 32'h0002_0000;
    req_a[3*N +: N] = 32'h0001_0000;
    req_b[3*N +: N] = 32'h8001_0000;
    @(negedge clk);
    req_valid = 4'b1000;
    @(negedge clk); #1;
    hd  = rsp_data;
    hid = rsp_id;
    checks++;
    if (rsp_valid !== 1'b1 || hd !== 32'h0005_0000 || hid !== 2'd2) begin
      failures++;
      $display("FAIL bp_first got v=%b data=%h id=%0d want 1 00050000 2", rsp_valid, hd, hid);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== hd || rsp_id !== hid || req_ready !== '0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got v=%b data=%h id=%0d rdy=%b want 1 %h %0d 0000",
                 i, rsp_valid, rsp_data, rsp_id, req_ready, hd, hid);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL bp_resume got rdy=%b want 1000", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain("bp");
  endtask

  task automatic test_reset_midop();
    do_single(2, 32'h7FFF_0000, 32'h0002_0000, 32'h7FFE_0000, 1'b1, "pre");
    @(negedge clk);
    req_valid = 4'b0010;
    req_a[1*N +: N] = 32'h0001_0000;
    req_b[1*N +: N] = 32'h0001_0000;
    #1;
    checks++;
    if (ovr_count !== 16'd1) begin
      failures++;
      $display("FAIL pre_count got=%0d want 1", ovr_count);
    end
    @(negedge clk);
    req_valid = 4'b1001;
    req_a[0*N +: N] = 32'h0003_0000;
    req_b[0*N +: N] = 32'h0000_8000;
    req_a[3*N +: N] = 32'h0001_0000;
    req_b[3*N +: N] = 32'h0001_0000;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_data !== '0 ||
        rsp_ovr !== 1'b0 || ovr_count !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midop_reset got rdy=%b v=%b id=%0d d=%h o=%b cnt=%0d busy=%b want zeros",
               req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovr, ovr_count, busy);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL midop_grant got rdy=%b want 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain("midop");
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_basic();
    test_ovr_clear();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
